// File: rtl/psoa_sigmoid_pipe.sv
// psoa_sigmoid_pipe: three-stage streaming sigmoid evaluator.
//   f(a) = C0 + C1*a - C2*a^2 on |x| in [0, SAT_INT), saturating above,
//   with odd symmetry f(-x) = 1 - f(x). valid/ready handshake with full
//   backpressure: a stalled output freezes every stage.
// Optional build macro PSOA_TANH_EN adds a per-sample `mode` input that
// selects tanh(x) = 2*sigmoid(2x) - 1 instead of sigmoid(x).
module psoa_sigmoid_pipe #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int FRAC    = 10,
  parameter int C0      = 515,
  parameter int C1      = 265,
  parameter int C2      = 36,
  parameter int SAT_INT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       f_x
`ifdef PSOA_TANH_EN
  ,
  input  logic                   mode
`endif
);

  localparam int MW = 2*IN_W + 8;
  localparam int ONE = 1 << FRAC;
  localparam logic [IN_W-1:0] SAT_TH = IN_W'(SAT_INT << FRAC);
  localparam logic signed [IN_W-1:0] S_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] S_MIN = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [MW-1:0] C0_W = MW'(C0);
  localparam logic [MW-1:0] C1_W = MW'(C1);
  localparam logic [MW-1:0] C2_W = MW'(C2);
  localparam logic signed [MW-1:0] ONE_S = MW'(ONE);

  // 2*v saturated to the signed IN_W range (tanh argument scaling).
  function automatic logic signed [IN_W-1:0] dbl_sat(input logic signed [IN_W-1:0] v);
    if (v[IN_W-1] != v[IN_W-2]) return v[IN_W-1] ? S_MIN : S_MAX;
    return {v[IN_W-2:0], 1'b0};
  endfunction

  // |v| with the most negative code folded onto the largest positive one.
  function automatic logic [IN_W-1:0] abs_sat(input logic signed [IN_W-1:0] v);
    if (v == S_MIN) return S_MAX;
    if (v[IN_W-1])  return IN_W'(-v);
    return v;
  endfunction

  // Saturate/clamp to [0, ONE], mirror for negative inputs, optional tanh remap.
  function automatic logic [OUT_W-1:0] finish(input logic signed [MW-1:0] y,
                                              input logic sat, input logic neg,
                                              input logic md);
    logic signed [MW-1:0] yc;
    logic signed [MW-1:0] f;
    if (sat)             yc = ONE_S;
    else if (y < 0)      yc = '0;
    else if (y > ONE_S)  yc = ONE_S;
    else                 yc = y;
    f = neg ? (ONE_S - yc) : yc;
    if (md) f = (f <<< 1) - ONE_S;
    return OUT_W'(f);
  endfunction

  logic stall, en;
  logic vld_p0, vld_p1, vld_p2;
  logic neg_p0, sat_p0, neg_p1, sat_p1;
  logic [IN_W-1:0] a_p0;
  logic signed [MW-1:0] y_p1;
  logic [OUT_W-1:0] f_p2;
  logic signed [IN_W-1:0] x_eff;
  logic [IN_W-1:0] a_c;
  logic [MW-1:0] a_w, t1_c, t2_c;
  logic signed [MW-1:0] y_c;
  logic md_p1;

  assign stall     = vld_p2 & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = vld_p2;
  assign f_x       = f_p2;

`ifdef PSOA_TANH_EN
  logic md_p0, md_p1_r;
  assign x_eff = mode ? dbl_sat(x) : x;
  assign md_p1 = md_p1_r;
`else
  assign x_eff = x;
  assign md_p1 = 1'b0;
`endif

  assign a_c = abs_sat(x_eff);

  // ---- stage 1 -> 2 boundary: sign, magnitude, saturation flag ----
  // Stage 1 data registers; no reset needed, qualified by vld_p0.
  always_ff @(posedge clk) begin
    if (en) begin
      a_p0   <= a_c;
      neg_p0 <= x_eff[IN_W-1];
      sat_p0 <= (a_c >= SAT_TH);
`ifdef PSOA_TANH_EN
      md_p0  <= mode;
`endif
    end
  end

  // Full-precision polynomial; MW is wide enough that nothing truncates.
  assign a_w  = MW'(a_p0);
  assign t2_c = (C2_W * a_w * a_w) >> (2*FRAC);
  assign t1_c = (C1_W * a_w) >> FRAC;
  assign y_c  = $signed(C0_W + t1_c - t2_c);

  // ---- stage 2 -> 3 boundary: raw polynomial value ----
  // Stage 2 data registers; no reset needed, qualified by vld_p1.
  always_ff @(posedge clk) begin
    if (en) begin
      y_p1    <= y_c;
      neg_p1  <= neg_p0;
      sat_p1  <= sat_p0;
`ifdef PSOA_TANH_EN
      md_p1_r <= md_p0;
`endif
    end
  end

  // ---- stage 3 / output boundary ----
  // Valid bits and the visible result; f_x must read zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      f_p2   <= '0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      f_p2   <= finish(y_p1, sat_p1, neg_p1, md_p1);
    end
  end

endmodule

// File: tb/tb_psoa_sigmoid_pipe.sv
// tb_psoa_sigmoid_pipe: vector table, stall/reset sequences and a long
// randomised stream checked against an arithmetic reference model.
module tb_psoa_sigmoid_pipe;
  localparam int ONE = 1024;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [15:0] x;
  logic [15:0] f_x;
  logic mode;

  always #5 clk = ~clk;

  psoa_sigmoid_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .f_x(f_x)
`ifdef PSOA_TANH_EN
    , .mode(mode)
`endif
  );

  typedef struct { int exp; int acc; } sb_t;
  typedef struct { int x; bit md; int exp; } vec_t;

  sb_t  sbq[$];
  vec_t tbl[$];
  int n_pass = 0, n_total = 0, cyc = 0;
  bit chk_lat = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: sigmoid straight from the piecewise formula using integer division.
  function automatic int model(input int xv, input bit md);
    longint s, a, y, f;
    s = xv;
    if (md) begin
      s = 2 * s;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
    end
    a = (s < 0) ? -s : s;
    if (a > 32767) a = 32767;
    if (a >= 4 * ONE) y = ONE;
    else begin
      y = 515 + (265 * a) / ONE - (36 * a * a) / (ONE * ONE);
      if (y < 0) y = 0;
      if (y > ONE) y = ONE;
    end
    f = (s < 0) ? ONE - y : y;
    if (md) f = 2 * f - ONE;
    return int'(f);
  endfunction

  // One clock cycle: drive at negedge, then score both handshakes of this cycle.
  task automatic step(input bit iv, input int xv, input bit md, input bit ordy,
                      input int expv, output bit acc);
    sb_t e;
    @(negedge clk);
    in_valid = iv; x = 16'(xv); mode = md; out_ready = ordy;
    #1;
    cyc++;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) check("unexpected_out", int'(f_x), -1);
      else begin
        e = sbq.pop_front();
        check("f_x", int'(f_x), e.exp & 'hFFFF);
        if (chk_lat) check("latency", cyc - e.acc, 3);
      end
    end
    acc = iv && in_ready;
    if (acc) sbq.push_back('{expv, cyc});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int idx, stall_left, held, sent;
    int xs[8];

    rst = 1'b1; in_valid = 1'b0; x = '0; out_ready = 1'b1; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_f_x", int'(f_x), 0);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_in_ready", int'(in_ready), 1);

    // Directed vectors, back-to-back, never stalled.
    tbl.push_back('{0, 0, 515});     tbl.push_back('{1024, 0, 744});
    tbl.push_back('{2048, 0, 901});  tbl.push_back('{4095, 0, 999});
    tbl.push_back('{-1024, 0, 280}); tbl.push_back('{-2048, 0, 123});
    tbl.push_back('{4096, 0, 1024}); tbl.push_back('{-4096, 0, 0});
    tbl.push_back('{-32768, 0, 0});  tbl.push_back('{32767, 0, 1024});
    tbl.push_back('{-4095, 0, 25});  tbl.push_back('{4097, 0, 1024});
`ifdef PSOA_TANH_EN
    tbl.push_back('{1024, 1, 778});  tbl.push_back('{1024, 0, 744});
    tbl.push_back('{0, 1, 6});       tbl.push_back('{1024, 0, 744});
    tbl.push_back('{-1024, 1, -778}); tbl.push_back('{1024, 0, 744});
`endif
    chk_lat = 1;
    foreach (tbl[i]) begin
      step(1, tbl[i].x, tbl[i].md, 1, tbl[i].exp, acc);
      check("tbl_accept", int'(acc), 1);
    end
    repeat (5) step(0, 0, 0, 1, 0, acc);
    check("tbl_drained", sbq.size(), 0);

    // Stall for 5 cycles in the middle of an 8-sample stream.
    chk_lat = 0;
    for (int i = 0; i < 8; i++) xs[i] = i * 700 - 2800;
    idx = 0; stall_left = -1; held = 0;
    for (int c = 0; c < 60 && (idx < 8 || sbq.size() > 0); c++) begin
      if (idx == 5 && stall_left < 0) stall_left = 5;
      step(idx < 8, (idx < 8) ? xs[idx] : 0, 0, !(stall_left > 0),
           (idx < 8) ? model(xs[idx], 0) : 0, acc);
      if (acc) idx++;
      if (stall_left > 0) begin
        if (stall_left == 5) begin
          held = int'(f_x);
          check("stall_out_valid", int'(out_valid), 1);
        end
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_f_x_hold", int'(f_x), held);
        stall_left--;
      end
    end
    check("stall_all_sent", idx, 8);
    check("stall_drained", sbq.size(), 0);

    // Reset with three samples in flight.
    for (int i = 0; i < 3; i++) step(1, 1024, 0, 0, 744, acc);
    step(0, 0, 0, 0, 0, acc);
    check("pre_rst_out_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_f_x", int'(f_x), 0);
    sbq.delete();
    @(negedge clk) rst = 1'b0;
    repeat (6) step(0, 0, 0, 1, 0, acc);
    chk_lat = 1;
    step(1, 0, 0, 1, 515, acc);
    repeat (4) step(0, 0, 0, 1, 0, acc);
    check("post_rst_drained", sbq.size(), 0);

    // Randomised stream against the reference model.
    chk_lat = 0;
    sent = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      int xv;
      bit md, iv, ordy;
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) xv = int'($urandom_range(0, 65535)) - 32768;
      else xv = int'($urandom_range(0, 10000)) - 5000;
`ifdef PSOA_TANH_EN
      md = $urandom_range(0, 1) != 0;
`else
      md = 1'b0;
`endif
      step(iv, xv, md, ordy, model(xv, md), acc);
      if (acc) sent++;
    end
    for (int c = 0; c < 50 && sbq.size() > 0; c++) step(0, 0, 0, 1, 0, acc);
    check("rand_sent", sent, 10000);
    check("rand_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
